bit_or_event_mon: RTL

BIT_OR_EVENT_MON -- requirements
Module: bit_or_event_mon

---
 rtl/bit_or_event_mon.sv | 110 +++++++++++
 1 files changed

// File: rtl/bit_or_event_mon.sv
// Per-channel combine (OR/AND/XOR/NOR) of one operand bit with saturating rise counters; sticky/irq only with BIT_OR_EVENT_MON_STICKY_EN.
// Latency: c/c_valid 1 cycle after the in_valid sample, irq 1 cycle after sticky; no backpressure, every sample is accepted.
module bit_or_event_mon #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4,
  parameter int BIT_IDX  = 0,
  parameter int CNT_W    = 8,
  localparam int SEL_W   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  input  logic [CHANNELS*WIDTH-1:0] a,
  input  logic [CHANNELS*WIDTH-1:0] b,
  input  logic [1:0]                mode,
  input  logic                      clr,
  input  logic [SEL_W-1:0]          cnt_sel,
  output logic [CHANNELS-1:0]       c,
  output logic                      c_valid,
  output logic [CNT_W-1:0]          cnt_rd,
  output logic [CHANNELS-1:0]       sticky,
  output logic                      irq
);

  logic [CHANNELS-1:0] res;
  logic [CHANNELS-1:0] rise;
  logic [CHANNELS-1:0] c_q, c_d;
  logic                c_valid_q;
  logic [CNT_W-1:0]    cnt_q [CHANNELS];
  logic [CNT_W-1:0]    cnt_d [CHANNELS];

  // Only bit BIT_IDX of each operand lane participates.
  logic unused_ops;
  assign unused_ops = ^{a, b};

  always_comb begin
    res = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      case (mode)
        2'b00:   res[k] =   a[k*WIDTH+BIT_IDX] | b[k*WIDTH+BIT_IDX];
        2'b01:   res[k] =   a[k*WIDTH+BIT_IDX] & b[k*WIDTH+BIT_IDX];
        2'b10:   res[k] =   a[k*WIDTH+BIT_IDX] ^ b[k*WIDTH+BIT_IDX];
        default: res[k] = ~(a[k*WIDTH+BIT_IDX] | b[k*WIDTH+BIT_IDX]);
      endcase
    end
  end

  assign rise = {CHANNELS{in_valid}} & res & ~c_q;
  assign c_d  = in_valid ? res : c_q;

  // clr wins over a same-cycle rise for the counters.
  always_comb begin
    for (int k = 0; k < CHANNELS; k++) begin
      cnt_d[k] = cnt_q[k];
      if (clr) begin
        cnt_d[k] = '0;
      end else if (rise[k] && (cnt_q[k] != {CNT_W{1'b1}})) begin
        cnt_d[k] = cnt_q[k] + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      c_q       <= '0;
      c_valid_q <= 1'b0;
      for (int k = 0; k < CHANNELS; k++) cnt_q[k] <= '0;
    end else begin
      c_q       <= c_d;
      c_valid_q <= in_valid;
      for (int k = 0; k < CHANNELS; k++) cnt_q[k] <= cnt_d[k];
    end
  end

  always_comb begin
    cnt_rd = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      if (cnt_sel == SEL_W'(k)) cnt_rd = cnt_q[k];
    end
  end

  assign c       = c_q;
  assign c_valid = c_valid_q;

`ifdef BIT_OR_EVENT_MON_STICKY_EN
  logic [CHANNELS-1:0] sticky_q, sticky_d;
  logic                irq_q, irq_d;

  // A same-cycle rise beats clr so the event is never lost.
  assign sticky_d = rise | (sticky_q & ~{CHANNELS{clr}});
  assign irq_d    = |sticky_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sticky_q <= '0;
      irq_q    <= 1'b0;
    end else begin
      sticky_q <= sticky_d;
      irq_q    <= irq_d;
    end
  end

  assign sticky = sticky_q;
  assign irq    = irq_q;
`else
  assign sticky = '0;
  assign irq    = 1'b0;
`endif

endmodule
